bcd_cnt_div: RTL and testbench
==============================

# bcd_cnt_div

Parametrised cascaded-BCD prescaler: the next generation of the fixed 1 Hz divider. It counts enabled clock cycles in a DIGITS-wide BCD counter, wraps at a runtime-programmable BCD terminal count, and emits per-decade carry enables, a one-cycle wrap tick and a square wave at half the tick rate. It sits between the board clock and the display and timekeeping logic, replacing hard-wired divide-by-10^N chains.

## Interface
- DIGITS, default 3: number of BCD decades; legal range 1..8.
- sys_clk  in  1  system clock; all state changes on its rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- cnt_en  in  1  count enable; the counter advances one step on each edge where it is high.
- clr  in  1  synchronous clear; has priority over cnt_en.
- tc_bcd  in  4*DIGITS  terminal count in BCD, digit 0 in bits [3:0]; sampled only at load points.
- cnt  out  4*DIGITS  current BCD count (registered).
- carry  out  DIGITS  decade enables (combinational).
- tick  out  1  one-cycle pulse marking a wrap (registered).
- sq_out  out  1  square wave that toggles on every wrap (registered).

## Operation
- Internal terminal register tc_q, 4*DIGITS bits.
- Load points for tc_q: every clr cycle and every wrap cycle. tc_q takes tc_bcd on these edges.
- Digit clamping at load: any tc_bcd digit above 9 is loaded as 9.
- Between load points, tc_q ignores changes on tc_bcd. A new terminal count takes effect from the next period. The count therefore never passes tc_q.
- Priority on each edge: sys_rst, then clr, then cnt_en.
  - clr: cnt becomes 0, tick becomes 0, sq_out becomes 0, tc_q is loaded.
  - cnt_en with cnt == tc_q (wrap): cnt becomes 0, tick becomes 1, sq_out toggles, tc_q is loaded.
  - cnt_en with cnt != tc_q: BCD increment. Digit i becomes 0 and carries into digit i+1 when digits 0..i are all 9; otherwise digit i increments. tick becomes 0.
  - cnt_en low, no clr: cnt, tc_q and sq_out hold; tick becomes 0.
- carry[i] = cnt_en AND (digits 0..i of cnt all equal 9). carry[i] is not qualified by tc_q. It is the decade-rollover enable for downstream logic.
- Divide ratio = BCD value of tc_q + 1 enabled cycles per tick. sq_out period is twice that.
- tc_q == 0: every enabled edge is a wrap. tick stays high for as long as cnt_en stays high, and sq_out toggles on each enabled edge.

## Timing
- Reset values: cnt = 0, tick = 0, sq_out = 0, tc_q = all digits 9 (divide by 10^DIGITS). carry is 0 while cnt_en is low.
- Reset is asynchronous on assertion. The first count occurs on the first rising edge with sys_rst low and cnt_en high.
- Wrap latency: cnt_en is high at edge k with cnt == tc_q. After edge k, cnt = 0, tick = 1 and sq_out has toggled. tick falls after edge k+1 unless edge k+1 is also a wrap.
- carry is combinational and valid in the same cycle as cnt and cnt_en.
- Reset asserted mid-count forces all state to its reset value immediately, with no clock needed. Any pending tick is lost.
- clr and a wrap on the same edge: clr wins, so tick = 0 and sq_out = 0.

## Test plan
- DIGITS=3, reset release, cnt_en held at 1, tc_bcd unchanged:
  - tick is high on the 1000th edge after reset release and every 1000 edges after that.
  - carry[0] pulses every 10 cycles, carry[1] every 100, carry[2] every 1000.
  - sq_out period is 2000 cycles.
- tc_bcd = 0x059, then clr:
  - The first tick comes 60 enabled edges after clr, then every 60.
  - Changing tc_bcd to 0x019 mid-period does not alter the current period. The period after the next wrap is 20.
- tc_bcd = 0x0A5, then clr: the value is clamped to 0x095, giving a period of 96 cycles.
- cnt_en toggled 1/0 every cycle with the default terminal count: a tick arrives every 2000 cycles, and cnt holds during low cycles.
- clr asserted at cnt = 0x437: the next edge gives cnt = 0, tick = 0, sq_out = 0. clr asserted together with a wrap gives tick = 0.
- sys_rst pulsed asynchronously, between clock edges, at cnt = 0x998:
  - cnt becomes 0 immediately.
  - tc_q returns to 0x999, even if it was previously programmed to another value.
  - No tick is produced.
- tc_bcd = 0x000 with cnt_en held at 1: tick is held at 1 continuously, sq_out toggles every cycle, and cnt stays at 0.

Source files
------------

// File: rtl/bcd_cnt_div.sv
// Cascaded-BCD prescaler: counts enabled cycles up to a programmable BCD
// terminal count, emitting decade carries, a wrap tick and a half-rate square wave.
module bcd_cnt_div #(
  parameter int DIGITS = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  cnt_en,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   tc_bcd,
  output logic [4*DIGITS-1:0]   cnt,
  output logic [DIGITS-1:0]     carry,
  output logic                  tick,
  output logic                  sq_out
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] TC_RST = {DIGITS{4'h9}};

  logic [W-1:0]      tc_q;
  logic [DIGITS-1:0] nines;
  logic              wrap;

  // Non-decimal digits (A..F) are loaded as 9 so the count can still reach tc_q.
  function automatic logic [W-1:0] clamp_tc(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] nines_prefix(input logic [W-1:0] v);
    logic [DIGITS-1:0] p;
    logic              run;
    run = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      run  = run & (v[4*i +: 4] == 4'd9);
      p[i] = run;
    end
    return p;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         cin;
    cin = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cin) begin
        r[4*i +: 4] = (v[4*i +: 4] == 4'd9) ? 4'd0 : v[4*i +: 4] + 4'd1;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
      cin = cin & (v[4*i +: 4] == 4'd9);
    end
    return r;
  endfunction

  always_comb begin
    nines = nines_prefix(cnt);
    carry = nines & {DIGITS{cnt_en}};
    wrap  = cnt_en && (cnt == tc_q);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt    <= '0;
      tick   <= 1'b0;
      sq_out <= 1'b0;
      tc_q   <= TC_RST;
    end else if (clr) begin
      cnt    <= '0;
      tick   <= 1'b0;
      sq_out <= 1'b0;
      tc_q   <= clamp_tc(tc_bcd);
    end else if (wrap) begin
      cnt    <= '0;
      tick   <= 1'b1;
      sq_out <= ~sq_out;
      tc_q   <= clamp_tc(tc_bcd);
    end else if (cnt_en) begin
      cnt    <= bcd_inc(cnt);
      tick   <= 1'b0;
    end else begin
      tick   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_cnt_div.sv
// Directed bench for bcd_cnt_div (DIGITS=3): vector table plus multi-cycle sequences.
module tb_bcd_cnt_div;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cnt_en  = 1'b0;
  logic        clr     = 1'b0;
  logic [11:0] tc_bcd  = 12'h999;
  logic [11:0] cnt;
  logic [2:0]  carry;
  logic        tick;
  logic        sq_out;

  int checks = 0;
  int errors = 0;

  bcd_cnt_div #(.DIGITS(3)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .cnt_en  (cnt_en),
    .clr     (clr),
    .tc_bcd  (tc_bcd),
    .cnt     (cnt),
    .carry   (carry),
    .tick    (tick),
    .sq_out  (sq_out)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        clr;
    logic        en;
    logic [11:0] tc;
    logic [2:0]  carry;
    logic [11:0] cnt;
    logic        tick;
    logic        sq;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic c, input logic e, input logic [11:0] t,
                              input logic [2:0] ca, input logic [11:0] n,
                              input logic tk, input logic s);
    vec_t v;
    v.clr = c; v.en = e; v.tc = t; v.carry = ca; v.cnt = n; v.tick = tk; v.sq = s;
    return v;
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    logic [3:0] d0, d1, d2;
    d0 = 4'(n % 10);
    d1 = 4'((n / 10) % 10);
    d2 = 4'((n / 100) % 10);
    return {d2, d1, d0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic async_rst(input string nm);
    cnt_en = 1'b0;
    clr    = 1'b0;
    #2 sys_rst = 1'b1;
    #1;
    chk({nm, "_cnt"},  32'(cnt),    32'h0);
    chk({nm, "_tick"}, 32'(tick),   32'h0);
    chk({nm, "_sq"},   32'(sq_out), 32'h0);
    #2 sys_rst = 1'b0;
    step();
  endtask

  task automatic run_until_tick(input int max, output int n);
    n = 0;
    while (n < max) begin
      step();
      n++;
      if (tick) break;
    end
  endtask

  int n, ticks, e;
  logic en_k;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(1, 0, 12'h002, 3'b000, 12'h000, 0, 0);
    tbl[1]  = mk(0, 1, 12'h002, 3'b000, 12'h001, 0, 0);
    tbl[2]  = mk(0, 0, 12'h002, 3'b000, 12'h001, 0, 0);
    tbl[3]  = mk(0, 1, 12'h000, 3'b000, 12'h002, 0, 0);
    tbl[4]  = mk(0, 1, 12'h000, 3'b000, 12'h000, 1, 1);
    tbl[5]  = mk(0, 1, 12'h000, 3'b000, 12'h000, 1, 0);
    tbl[6]  = mk(0, 0, 12'h000, 3'b000, 12'h000, 0, 0);
    tbl[7]  = mk(0, 1, 12'h000, 3'b000, 12'h000, 1, 1);
    tbl[8]  = mk(1, 1, 12'h003, 3'b000, 12'h000, 0, 0);
    tbl[9]  = mk(0, 1, 12'h003, 3'b000, 12'h001, 0, 0);
    tbl[10] = mk(0, 1, 12'h003, 3'b000, 12'h002, 0, 0);
    tbl[11] = mk(0, 1, 12'h003, 3'b000, 12'h003, 0, 0);
    tbl[12] = mk(0, 1, 12'h003, 3'b000, 12'h000, 1, 1);

    #23 sys_rst = 1'b0;
    step();
    chk("rst_cnt",   32'(cnt),    32'h0);
    chk("rst_tick",  32'(tick),   32'h0);
    chk("rst_sq",    32'(sq_out), 32'h0);
    chk("rst_carry", 32'(carry),  32'h0);

    // Short vector table: hold, tc latching at wraps, tc==0, clr during wrap.
    foreach (tbl[i]) begin
      clr = tbl[i].clr; cnt_en = tbl[i].en; tc_bcd = tbl[i].tc;
      #1;
      chk($sformatf("tbl%0d_carry", i), 32'(carry), 32'(tbl[i].carry));
      step();
      chk($sformatf("tbl%0d_cnt", i),  32'(cnt),    32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_tick", i), 32'(tick),   32'(tbl[i].tick));
      chk($sformatf("tbl%0d_sq", i),   32'(sq_out), 32'(tbl[i].sq));
    end
    clr = 1'b0;

    // Default terminal count, free running: compare against decimal count.
    tc_bcd = 12'h999;
    async_rst("rstA");
    cnt_en = 1'b1;
    for (int k = 1; k <= 3000; k++) begin
      automatic int v = (k - 1) % 1000;
      #1;
      chk("A_carry", 32'(carry),
          32'({3'(v == 999), 3'(0)} >> 3) | 32'({(v % 100) == 99, (v % 10) == 9} == 2'b11 ? 3'b011 :
                                               ((v % 10) == 9 ? 3'b001 : 3'b000)) | (v == 999 ? 32'h4 : 32'h0));
      step();
      chk("A_cnt",  32'(cnt),    32'(to_bcd(k % 1000)));
      chk("A_tick", 32'(tick),   32'((k % 1000) == 0));
      chk("A_sq",   32'(sq_out), 32'((k / 1000) % 2));
    end

    // Programmed tc 059, then 019 changed mid-period.
    async_rst("rstB");
    tc_bcd = 12'h059; clr = 1'b1; cnt_en = 1'b1;
    step();
    clr = 1'b0;
    run_until_tick(200, n);
    chk("B_first", 32'(n), 32'd60);
    repeat (10) step();
    tc_bcd = 12'h019;
    run_until_tick(200, n);
    chk("B_second", 32'(n + 10), 32'd60);
    run_until_tick(200, n);
    chk("B_third", 32'(n), 32'd20);

    // Digit clamp: 0A5 behaves as 095.
    tc_bcd = 12'h0A5; clr = 1'b1;
    step();
    clr = 1'b0;
    run_until_tick(200, n);
    chk("C_first", 32'(n), 32'd96);
    run_until_tick(200, n);
    chk("C_second", 32'(n), 32'd96);

    // Enable toggling every cycle.
    tc_bcd = 12'h999;
    async_rst("rstD");
    e = 0; ticks = 0;
    for (int k = 0; k < 4000; k++) begin
      en_k = (k % 2) == 0;
      cnt_en = en_k;
      step();
      if (en_k) e++;
      if (tick) ticks++;
      chk("D_cnt",  32'(cnt),  32'(to_bcd(e % 1000)));
      chk("D_tick", 32'(tick), 32'(en_k && (e % 1000) == 0));
    end
    chk("D_ticks", 32'(ticks), 32'd2);

    // Clear mid-count at 437.
    async_rst("rstE");
    cnt_en = 1'b1;
    repeat (437) step();
    chk("E_cnt437", 32'(cnt), 32'h437);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("E_clr_cnt",  32'(cnt),    32'h0);
    chk("E_clr_tick", 32'(tick),   32'h0);
    chk("E_clr_sq",   32'(sq_out), 32'h0);

    // Async reset restores tc_q to 999 and drops pending state.
    tc_bcd = 12'h059; clr = 1'b1; cnt_en = 1'b1;
    step();
    clr = 1'b0;
    repeat (30) step();
    chk("F_cnt30", 32'(cnt), 32'h030);
    async_rst("F_rst1");
    cnt_en = 1'b1; ticks = 0;
    repeat (998) begin
      step();
      if (tick) ticks++;
    end
    chk("F_cnt998", 32'(cnt), 32'h998);
    chk("F_noticks", 32'(ticks), 32'd0);
    async_rst("F_rst2");
    cnt_en = 1'b1;
    run_until_tick(1100, n);
    chk("F_period", 32'(n), 32'd1000);

    // Terminal count zero: tick held, square wave toggles every edge.
    tc_bcd = 12'h000; clr = 1'b1;
    step();
    clr = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("G_tick", 32'(tick),   32'h1);
      chk("G_cnt",  32'(cnt),    32'h0);
      chk("G_sq",   32'(sq_out), 32'(k % 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
